univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg.sv | 91 +++++++++
 tb/tb_univ_shift_reg.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left or parallel load, with a saturating shift counter.
// Latency: one cycle; Q, cnt and done update on the enabled rising edge. sout is combinational from Q and mode.
// Backpressure: none; En=0 stalls all state, and reset wins over En and mode.
module univ_shift_reg #(
   parameter int WIDTH  = 8,
   parameter bit ROTATE = 1'b0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       En,
   input  logic [1:0]                 mode,
   input  logic [WIDTH-1:0]           D,
   input  logic                       sin_r,
   input  logic                       sin_l,
   output logic [WIDTH-1:0]           Q,
   output logic                       sout,
   output logic [$clog2(WIDTH+1)-1:0] cnt,
   output logic                       done
);

   localparam int CNT_W = $clog2(WIDTH+1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_RIGHT = 2'b01;
   localparam logic [1:0] MODE_LEFT  = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   logic [WIDTH-1:0] q_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             done_nxt;
   logic [CNT_W-1:0] cnt_sat;
   logic             fill_r;
   logic             fill_l;

   // Bit entering the vacated end: the recirculated edge bit when rotating, else the serial input.
   assign fill_r = ROTATE ? Q[0]       : sin_r;
   assign fill_l = ROTATE ? Q[WIDTH-1] : sin_l;

   // Shift count after one more shift; sticks at WIDTH so Q keeps moving while the count stays pinned.
   assign cnt_sat = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

   // Outgoing bit: LSB while shifting right, MSB for every other mode.
   assign sout = (mode == MODE_RIGHT) ? Q[0] : Q[WIDTH-1];

   // Next-state decode; every path starts from "hold" so disabled cycles and mode 00 need no extra terms.
   always_comb begin
      q_nxt    = Q;
      cnt_nxt  = cnt;
      done_nxt = done;
      if (En) begin
         case (mode)
            MODE_HOLD: begin
               q_nxt    = Q;
               cnt_nxt  = cnt;
               done_nxt = done;
            end
            MODE_RIGHT: begin
               q_nxt    = {fill_r, Q[WIDTH-1:1]};
               cnt_nxt  = cnt_sat;
               done_nxt = (cnt_sat == CNT_MAX);
            end
            MODE_LEFT: begin
               q_nxt    = {Q[WIDTH-2:0], fill_l};
               cnt_nxt  = cnt_sat;
               done_nxt = (cnt_sat == CNT_MAX);
            end
            MODE_LOAD: begin
               // A load restarts the count even on the cycle a shift would have saturated it.
               q_nxt    = D;
               cnt_nxt  = '0;
               done_nxt = 1'b0;
            end
         endcase
      end
   end

   // State register; synchronous reset aborts any shift sequence in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         Q    <= '0;
         cnt  <= '0;
         done <= 1'b0;
      end else begin
         Q    <= q_nxt;
         cnt  <= cnt_nxt;
         done <= done_nxt;
      end
   end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: one shifting and one rotating instance driven in lockstep.
// Latency: each vector is applied, then checked one rising edge later (sout checked before the edge).
// Backpressure: none; En toggled directly by the vectors.
module tb_univ_shift_reg;

   logic       clk;
   logic       reset;
   logic       En;
   logic [1:0] mode;
   logic [7:0] D;
   logic       sin_r;
   logic       sin_l;

   logic [7:0] q0, q1;
   logic       sout0, sout1;
   logic [3:0] cnt0, cnt1;
   logic       done0, done1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       rst;
      logic       en;
      logic [1:0] md;
      logic [7:0] d;
      logic       sr;
      logic       sl;
      logic       chk_so;
      logic       so;
      logic [7:0] q_sh;
      logic [7:0] q_rot;
      logic [3:0] c;
      logic       dn;
   } vec_t;

   vec_t vecs[$];

   univ_shift_reg #(.WIDTH(8), .ROTATE(1'b0)) u_dut_shift (
      .clk(clk), .reset(reset), .En(En), .mode(mode), .D(D),
      .sin_r(sin_r), .sin_l(sin_l),
      .Q(q0), .sout(sout0), .cnt(cnt0), .done(done0)
   );

   univ_shift_reg #(.WIDTH(8), .ROTATE(1'b1)) u_dut_rot (
      .clk(clk), .reset(reset), .En(En), .mode(mode), .D(D),
      .sin_r(sin_r), .sin_l(sin_l),
      .Q(q1), .sout(sout1), .cnt(cnt1), .done(done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic r, input logic en, input logic [1:0] m, input logic [7:0] d,
                      input logic sr, input logic sl, input logic cs, input logic so,
                      input logic [7:0] qs, input logic [7:0] qr, input logic [3:0] c, input logic dn);
      vec_t v;
      v.rst = r; v.en = en; v.md = m; v.d = d; v.sr = sr; v.sl = sl;
      v.chk_so = cs; v.so = so; v.q_sh = qs; v.q_rot = qr; v.c = c; v.dn = dn;
      vecs.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; En = 1'b0; mode = 2'b00; D = 8'h00; sin_r = 1'b0; sin_l = 1'b0;

      //  rst en  mode   D     sr sl cs so  Q(shift) Q(rot) cnt done
      add(1, 0, 2'b00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);  // reset state
      add(0, 1, 2'b11, 8'hA5, 0, 0, 1, 0, 8'hA5, 8'hA5, 0, 0);  // load A5
      add(0, 1, 2'b01, 8'h00, 1, 0, 1, 1, 8'hD2, 8'hD2, 1, 0);  // 8 right shifts, sin_r=1
      add(0, 1, 2'b01, 8'h00, 1, 0, 1, 0, 8'hE9, 8'h69, 2, 0);
      add(0, 1, 2'b01, 8'h00, 1, 0, 1, 1, 8'hF4, 8'hB4, 3, 0);
      add(0, 1, 2'b01, 8'h00, 1, 0, 1, 0, 8'hFA, 8'h5A, 4, 0);
      add(0, 1, 2'b01, 8'h00, 1, 0, 1, 0, 8'hFD, 8'h2D, 5, 0);
      add(0, 1, 2'b01, 8'h00, 1, 0, 1, 1, 8'hFE, 8'h96, 6, 0);
      add(0, 1, 2'b01, 8'h00, 1, 0, 1, 0, 8'hFF, 8'h4B, 7, 0);
      add(0, 1, 2'b01, 8'h00, 1, 0, 1, 1, 8'hFF, 8'hA5, 8, 1);  // done on 8th edge
      add(0, 1, 2'b01, 8'h00, 1, 0, 1, 1, 8'hFF, 8'hD2, 8, 1);  // saturated, Q still moves
      add(0, 1, 2'b10, 8'h00, 1, 0, 1, 1, 8'hFE, 8'hA5, 8, 1);  // left shift, sin_l=0
      add(0, 0, 2'b01, 8'h00, 1, 1, 1, 0, 8'hFE, 8'hA5, 8, 1);  // En=0 hold x4
      add(0, 0, 2'b01, 8'h00, 1, 1, 1, 0, 8'hFE, 8'hA5, 8, 1);
      add(0, 0, 2'b01, 8'h00, 1, 1, 1, 0, 8'hFE, 8'hA5, 8, 1);
      add(0, 0, 2'b01, 8'h00, 1, 1, 1, 0, 8'hFE, 8'hA5, 8, 1);
      add(0, 1, 2'b00, 8'h55, 1, 1, 1, 1, 8'hFE, 8'hA5, 8, 1);  // mode 00 hold
      add(0, 1, 2'b11, 8'h3C, 0, 0, 1, 1, 8'h3C, 8'h3C, 0, 0);  // load clears done
      add(0, 1, 2'b10, 8'h00, 0, 1, 1, 0, 8'h79, 8'h78, 1, 0);  // left, sin_l=1
      add(0, 1, 2'b01, 8'h00, 0, 0, 1, 1, 8'h3C, 8'h3C, 2, 0);  // direction change keeps count
      add(1, 1, 2'b11, 8'hFF, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0);  // reset beats load
      add(0, 1, 2'b11, 8'h0F, 0, 0, 1, 0, 8'h0F, 8'h0F, 0, 0);  // load 0F, then 5 right shifts
      add(0, 1, 2'b01, 8'h00, 0, 0, 1, 1, 8'h07, 8'h87, 1, 0);
      add(0, 1, 2'b01, 8'h00, 0, 0, 1, 1, 8'h03, 8'hC3, 2, 0);
      add(0, 1, 2'b01, 8'h00, 0, 0, 1, 1, 8'h01, 8'hE1, 3, 0);
      add(0, 1, 2'b01, 8'h00, 0, 0, 1, 1, 8'h00, 8'hF0, 4, 0);
      add(0, 1, 2'b01, 8'h00, 0, 0, 1, 0, 8'h00, 8'h78, 5, 0);
      add(1, 1, 2'b11, 8'hAA, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0);  // reset+load mid-sequence
      add(0, 1, 2'b01, 8'h00, 1, 0, 1, 0, 8'h80, 8'h00, 1, 0);  // first shift after reset -> cnt=1
      add(0, 1, 2'b11, 8'h5A, 0, 0, 1, 1, 8'h5A, 8'h5A, 0, 0);  // load 5A, 7 left shifts
      add(0, 1, 2'b10, 8'h00, 0, 0, 1, 0, 8'hB4, 8'hB4, 1, 0);
      add(0, 1, 2'b10, 8'h00, 0, 0, 1, 1, 8'h68, 8'h69, 2, 0);
      add(0, 1, 2'b10, 8'h00, 0, 0, 1, 0, 8'hD0, 8'hD2, 3, 0);
      add(0, 1, 2'b10, 8'h00, 0, 0, 1, 1, 8'hA0, 8'hA5, 4, 0);
      add(0, 1, 2'b10, 8'h00, 0, 0, 1, 1, 8'h40, 8'h4B, 5, 0);
      add(0, 1, 2'b10, 8'h00, 0, 0, 1, 0, 8'h80, 8'h96, 6, 0);
      add(0, 1, 2'b10, 8'h00, 0, 0, 1, 1, 8'h00, 8'h2D, 7, 0);
      add(0, 1, 2'b11, 8'hC3, 0, 0, 1, 0, 8'hC3, 8'hC3, 0, 0);  // load where cnt would reach 8
      add(0, 1, 2'b11, 8'h81, 0, 0, 1, 1, 8'h81, 8'h81, 0, 0);  // load 81, 8 left shifts
      add(0, 1, 2'b10, 8'h00, 0, 0, 1, 1, 8'h02, 8'h03, 1, 0);
      add(0, 1, 2'b10, 8'h00, 0, 0, 1, 0, 8'h04, 8'h06, 2, 0);
      add(0, 1, 2'b10, 8'h00, 0, 0, 1, 0, 8'h08, 8'h0C, 3, 0);
      add(0, 1, 2'b10, 8'h00, 0, 0, 1, 0, 8'h10, 8'h18, 4, 0);
      add(0, 1, 2'b10, 8'h00, 0, 0, 1, 0, 8'h20, 8'h30, 5, 0);
      add(0, 1, 2'b10, 8'h00, 0, 0, 1, 0, 8'h40, 8'h60, 6, 0);
      add(0, 1, 2'b10, 8'h00, 0, 0, 1, 0, 8'h80, 8'hC0, 7, 0);
      add(0, 1, 2'b10, 8'h00, 0, 0, 1, 1, 8'h00, 8'h81, 8, 1);
      add(0, 0, 2'b11, 8'h00, 0, 0, 1, 0, 8'h00, 8'h81, 8, 1);  // disabled load is ignored

      @(negedge clk);
      foreach (vecs[i]) begin
         reset = vecs[i].rst; En = vecs[i].en; mode = vecs[i].md; D = vecs[i].d;
         sin_r = vecs[i].sr; sin_l = vecs[i].sl;
         #1;
         if (vecs[i].chk_so) check($sformatf("v%0d sout", i), 64'(sout0), 64'(vecs[i].so));
         tick();
         check($sformatf("v%0d q_shift", i), 64'(q0), 64'(vecs[i].q_sh));
         check($sformatf("v%0d q_rot", i), 64'(q1), 64'(vecs[i].q_rot));
         check($sformatf("v%0d cnt_shift", i), 64'(cnt0), 64'(vecs[i].c));
         check($sformatf("v%0d cnt_rot", i), 64'(cnt1), 64'(vecs[i].c));
         check($sformatf("v%0d done_shift", i), 64'(done0), 64'(vecs[i].dn));
         check($sformatf("v%0d done_rot", i), 64'(done1), 64'(vecs[i].dn));
      end

      // Inputs changing between edges must not move Q.
      reset = 1'b0; En = 1'b1; mode = 2'b11; D = 8'h01;
      #3;
      check("mid_cycle_q_shift", 64'(q0), 64'h00);
      check("mid_cycle_q_rot", 64'(q1), 64'h81);
      tick();
      check("load01_q_shift", 64'(q0), 64'h01);
      check("load01_cnt", 64'(cnt0), 64'h0);

      // sout selects by mode combinationally on a fixed Q=01.
      En = 1'b0;
      mode = 2'b01; #1; check("sout_right", 64'(sout0), 64'h1);
      mode = 2'b10; #1; check("sout_left", 64'(sout0), 64'h0);
      mode = 2'b00; #1; check("sout_hold", 64'(sout0), 64'h0);
      mode = 2'b11; #1; check("sout_load_rot", 64'(sout1), 64'h0);

      // Reset acts even with En low.
      reset = 1'b1; En = 1'b0; mode = 2'b01;
      tick();
      check("rst_en0_q", 64'(q0), 64'h00);
      check("rst_en0_cnt", 64'(cnt1), 64'h0);
      check("rst_en0_done", 64'(done1), 64'h0);
      check("rst_en0_sout", 64'(sout0), 64'h0);
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
